core_scheduler: RTL and testbench
=================================

CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_, input, 1: reset, synchronous and active-low; sampled only at posedge clk.
REQ-003 SHALL have ports pc_out_0..pc_out_3, input, 19 each: awaken request from core n; [18] valid, [17:16] target core, [15:0] start PC.
REQ-004 SHALL have ports pause_resume_0..pause_resume_3, input, 4 each: [3] valid, [2] 0=pause/1=resume, [1:0] target core.
REQ-005 SHALL have ports halt_0..halt_3, input, 1 each: core n has halted.
REQ-006 SHALL have ports pc_passed_0..pc_passed_3, output, 17 each: [16] start pulse, [15:0] start PC.
REQ-007 SHALL have ports stall_num_0..stall_num_3, output, 3 each: external stall depth for core n; 0 none, 6 freeze all stages.
REQ-008 SHALL have port core_state, output, 12: 3-bit state per core, core n at [3n+2:3n].
REQ-009 SHALL have port all_halted, output, 1: every core HALTED or OFF.
REQ-010 SHALL have port dropped_cnt, output, 8: saturating count of discarded requests.

Function
REQ-011 SHALL hold per-core state: OFF=0, RUNNING=1, PAUSED=2, HALTED=3.
REQ-012 SHALL accept requests only from RUNNING requesters; requests from OFF, PAUSED or HALTED cores are ignored and not counted.
REQ-013 SHALL treat each core as issuing at most one request per cycle; if pc_out[18] and pause_resume[3] are both set, awaken takes precedence and the other is ignored.
REQ-014 SHALL arbitrate per target core: among eligible requests naming target t, the winner is the first requester index at or after rr_ptr_t, modulo 4.
REQ-015 SHALL advance rr_ptr_t to winner+1 mod 4 on each grant; it is unchanged in cycles with no request for t.
REQ-016 SHALL drive stall_num_r = 6 combinationally, in the same cycle, for each losing requester r, so its writeback holds and it retries next cycle.
REQ-017 SHALL handle an awaken grant to target t in state OFF as follows: next cycle pc_passed_t = {1, pc}, held for exactly one cycle; t becomes RUNNING at the same edge.
REQ-018 SHALL discard an awaken grant to a non-OFF target without stalling the requester, and increment dropped_cnt.
REQ-019 SHALL transition a RUNNING target to PAUSED at the next edge on a pause grant; a core may pause itself.
REQ-020 SHALL transition a PAUSED target to RUNNING at the next edge on a resume grant.
REQ-021 SHALL discard, and count in dropped_cnt, a pause to a non-RUNNING target or a resume to a non-PAUSED target.
REQ-022 SHALL drive stall_num = 6 for every PAUSED core and 0 for cores in OFF, RUNNING or HALTED, except losers per REQ-016.
REQ-023 SHALL ignore requests from a core during its first RUNNING cycle after resume (resume guard), so a held self-pause is not re-executed.
REQ-024 SHALL move core n to HALTED from RUNNING or PAUSED when halt_n=1; HALTED is terminal until reset; halt_n is ignored in OFF.
REQ-025 SHALL let halt take priority over a same-cycle pause/resume grant to the same core.
REQ-026 SHALL hold dropped_cnt at 255 once saturated.
REQ-027 SHALL compute all_halted combinationally from registered state.

Reset
REQ-028 SHALL, while rst_=0 at an edge, set core 0 to RUNNING, cores 1-3 to OFF, all rr_ptr to 0 and dropped_cnt to 0.
REQ-029 SHALL drive pc_passed_0 = {1, 16'h0000} for the first cycle after rst_ rises; all other pc_passed = 0 and all stall_num = 0 during and after reset.
REQ-030 SHALL abandon in-flight grants and pulses when reset is asserted mid-operation; no pc_passed pulse is emitted in the cycle after a reset edge other than REQ-029.

Verification
REQ-031 SHALL cover: release reset -> pc_passed_0 = 17'h10000 for one cycle; core_state = 12'h001.
REQ-032 SHALL cover: core 0 pc_out_0 = {1, 2'd2, 16'h0100} -> next cycle pc_passed_2 = 17'h10100 for one cycle; core 2 RUNNING.
REQ-033 SHALL cover: cores 0 and 1 both RUNNING, both awaken core 3 in the same cycle with rr_ptr_3 = 1 -> core 1 wins; stall_num_0 = 6 that cycle; core 0 retry next cycle is dropped; dropped_cnt = 1.
REQ-034 SHALL cover: core 1 self-pause held for 3 cycles, then core 0 resumes core 1 -> stall_num_1 = 6 while PAUSED, 0 after resume; the guard cycle ignores the stale pause; core 1 stays RUNNING.
REQ-035 SHALL cover: halt_2 and a pause to core 2 in the same cycle -> core 2 HALTED; all cores halted -> all_halted = 1.
REQ-036 SHALL cover: 256 awakens to a RUNNING core -> dropped_cnt stops at 255; assert rst_=0 mid-sequence -> state returns to 12'h001, counter 0.

Source files
------------

// File: rtl/core_scheduler.sv
// Cross-core scheduler: arbitrates awaken/pause/resume requests per target core.
// Ports: pc_out_n/pause_resume_n/halt_n in, pc_passed_n/stall_num_n/core_state/all_halted/dropped_cnt out.
module core_scheduler (
  input  logic        clk,
  input  logic        rst_,
  input  logic [18:0] pc_out_0,
  input  logic [18:0] pc_out_1,
  input  logic [18:0] pc_out_2,
  input  logic [18:0] pc_out_3,
  input  logic [3:0]  pause_resume_0,
  input  logic [3:0]  pause_resume_1,
  input  logic [3:0]  pause_resume_2,
  input  logic [3:0]  pause_resume_3,
  input  logic        halt_0,
  input  logic        halt_1,
  input  logic        halt_2,
  input  logic        halt_3,
  output logic [16:0] pc_passed_0,
  output logic [16:0] pc_passed_1,
  output logic [16:0] pc_passed_2,
  output logic [16:0] pc_passed_3,
  output logic [2:0]  stall_num_0,
  output logic [2:0]  stall_num_1,
  output logic [2:0]  stall_num_2,
  output logic [2:0]  stall_num_3,
  output logic [11:0] core_state,
  output logic        all_halted,
  output logic [7:0]  dropped_cnt
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [3:0][18:0] pco;
  logic [3:0][3:0]  prv;
  logic [3:0]       hlt;

  assign pco = {pc_out_3, pc_out_2, pc_out_1, pc_out_0};
  assign prv = {pause_resume_3, pause_resume_2,
                pause_resume_1, pause_resume_0};
  assign hlt = {halt_3, halt_2, halt_1, halt_0};

  logic [3:0][1:0]  state_q, state_d;
  logic [3:0][1:0]  rr_q, rr_d;
  logic [3:0][15:0] pc_q, pc_d;
  logic [3:0]       guard_q, guard_d;
  logic [3:0]       pulse_q, pulse_d;
  logic             boot_q;
  logic [7:0]       drop_q, drop_d;

  logic [3:0]       req_vld;
  logic [3:0]       req_aw;
  logic [3:0]       req_res;
  logic [3:0][1:0]  req_tgt;
  logic [3:0][15:0] req_pc;
  logic [3:0]       win_vld;
  logic [3:0][1:0]  win_idx;
  logic [3:0]       lose;
  logic [3:0]       drop_t;
  logic [8:0]       drop_sum;

  // Awaken wins over pause/resume when a core raises both.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      req_vld[r] = (state_q[r] == ST_RUN) && !guard_q[r] &&
                   (pco[r][18] || prv[r][3]);
      req_aw[r]  = pco[r][18];
      req_res[r] = prv[r][2];
      req_tgt[r] = pco[r][18] ? pco[r][17:16] : prv[r][1:0];
      req_pc[r]  = pco[r][15:0];
    end
  end

  // Round-robin search starting at rr_q[t], wrapping mod 4.
  always_comb begin
    for (int t = 0; t < 4; t++) begin
      win_vld[t] = 1'b0;
      win_idx[t] = 2'd0;
      for (int k = 0; k < 4; k++) begin
        if (!win_vld[t] &&
            req_vld[rr_q[t] + 2'(k)] &&
            req_tgt[rr_q[t] + 2'(k)] == 2'(t)) begin
          win_vld[t] = 1'b1;
          win_idx[t] = rr_q[t] + 2'(k);
        end
      end
    end
    for (int r = 0; r < 4; r++) begin
      lose[r] = req_vld[r] && (win_idx[req_tgt[r]] != 2'(r));
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    pc_d    = pc_q;
    guard_d = '0;
    pulse_d = '0;
    drop_t  = '0;
    for (int t = 0; t < 4; t++) begin
      if (win_vld[t]) begin
        rr_d[t] = win_idx[t] + 2'd1;
        if (req_aw[win_idx[t]]) begin
          if (state_q[t] == ST_OFF) begin
            state_d[t] = ST_RUN;
            pulse_d[t] = 1'b1;
            pc_d[t]    = req_pc[win_idx[t]];
          end else begin
            drop_t[t] = 1'b1;
          end
        end else if (!req_res[win_idx[t]]) begin
          if (state_q[t] == ST_RUN) state_d[t] = ST_PAUSE;
          else                      drop_t[t]  = 1'b1;
        end else begin
          if (state_q[t] == ST_PAUSE) begin
            state_d[t] = ST_RUN;
            guard_d[t] = 1'b1;
          end else begin
            drop_t[t] = 1'b1;
          end
        end
      end
      // Halt overrides any same-cycle pause/resume outcome.
      if (hlt[t] && (state_q[t] == ST_RUN ||
                     state_q[t] == ST_PAUSE)) begin
        state_d[t] = ST_HALT;
        guard_d[t] = 1'b0;
      end
    end
    // Boot pulse launches core 0 at PC 0 once after reset.
    if (boot_q) begin
      pulse_d[0] = 1'b1;
      pc_d[0]    = 16'h0000;
    end
    drop_sum = {1'b0, drop_q};
    for (int t = 0; t < 4; t++) begin
      drop_sum = drop_sum + 9'(drop_t[t]);
    end
    drop_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= {ST_OFF, ST_OFF, ST_OFF, ST_RUN};
      rr_q    <= '0;
      pc_q    <= '0;
      guard_q <= '0;
      pulse_q <= '0;
      boot_q  <= 1'b1;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pc_q    <= pc_d;
      guard_q <= guard_d;
      pulse_q <= pulse_d;
      boot_q  <= 1'b0;
      drop_q  <= drop_d;
    end
  end

  logic [3:0][2:0] stall;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      stall[r] = (rst_ && (state_q[r] == ST_PAUSE || lose[r]))
                 ? 3'd6 : 3'd0;
    end
  end

  assign stall_num_0 = stall[0];
  assign stall_num_1 = stall[1];
  assign stall_num_2 = stall[2];
  assign stall_num_3 = stall[3];

  assign pc_passed_0 = pulse_q[0] ? {1'b1, pc_q[0]} : 17'h0;
  assign pc_passed_1 = pulse_q[1] ? {1'b1, pc_q[1]} : 17'h0;
  assign pc_passed_2 = pulse_q[2] ? {1'b1, pc_q[2]} : 17'h0;
  assign pc_passed_3 = pulse_q[3] ? {1'b1, pc_q[3]} : 17'h0;

  assign core_state = {1'b0, state_q[3], 1'b0, state_q[2],
                       1'b0, state_q[1], 1'b0, state_q[0]};

  logic [3:0] done;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      done[r] = (state_q[r] == ST_HALT) || (state_q[r] == ST_OFF);
    end
  end

  assign all_halted  = &done;
  assign dropped_cnt = drop_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler.
// Vector table plus scoreboard queue; hand-written reset/saturation sequences.
module tb_core_scheduler;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic [3:0][18:0] pc_out = '0;
  logic [3:0][3:0]  pr = '0;
  logic [3:0]       halt = '0;
  logic [3:0][16:0] pp;
  logic [3:0][2:0]  sn;
  logic [11:0]      cs;
  logic             ah;
  logic [7:0]       dc;

  always #5 clk = ~clk;

  core_scheduler dut (
    .clk(clk), .rst_(rst_),
    .pc_out_0(pc_out[0]), .pc_out_1(pc_out[1]),
    .pc_out_2(pc_out[2]), .pc_out_3(pc_out[3]),
    .pause_resume_0(pr[0]), .pause_resume_1(pr[1]),
    .pause_resume_2(pr[2]), .pause_resume_3(pr[3]),
    .halt_0(halt[0]), .halt_1(halt[1]),
    .halt_2(halt[2]), .halt_3(halt[3]),
    .pc_passed_0(pp[0]), .pc_passed_1(pp[1]),
    .pc_passed_2(pp[2]), .pc_passed_3(pp[3]),
    .stall_num_0(sn[0]), .stall_num_1(sn[1]),
    .stall_num_2(sn[2]), .stall_num_3(sn[3]),
    .core_state(cs), .all_halted(ah), .dropped_cnt(dc)
  );

  typedef struct {
    logic [3:0][18:0] pc;
    logic [3:0][3:0]  pr;
    logic [3:0]       halt;
    logic [3:0][2:0]  stall;
    logic [3:0][16:0] pp;
    logic [11:0]      st;
    logic [7:0]       drop;
    logic             ah;
  } vec_t;

  typedef struct {
    logic [3:0][16:0] pp;
    logic [11:0]      st;
    logic [7:0]       drop;
    logic             ah;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [18:0] aw(input logic [1:0] t,
                                     input logic [15:0] p);
    return {1'b1, t, p};
  endfunction

  function automatic logic [3:0] pz(input logic [1:0] t);
    return {2'b10, t};
  endfunction

  function automatic logic [3:0] rs(input logic [1:0] t);
    return {2'b11, t};
  endfunction

  function automatic vec_t mk(input logic [11:0] st,
                              input logic [7:0] drop,
                              input logic a);
    vec_t v;
    v = '{default: '0};
    v.st = st;
    v.drop = drop;
    v.ah = a;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [67:0] act,
                       input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " pc_passed"}, pp, e.pp);
      check({tag, " core_state"}, 68'(cs), 68'(e.st));
      check({tag, " dropped"}, 68'(dc), 68'(e.drop));
      check({tag, " all_halted"}, 68'(ah), 68'(e.ah));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    pc_out = v.pc;
    pr = v.pr;
    halt = v.halt;
    #1;
    check({tag, " stall"}, 68'(sn), 68'(v.stall));
    e.pp = v.pp;
    e.st = v.st;
    e.drop = v.drop;
    e.ah = v.ah;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic do_reset(input logic [18:0] pc0);
    logic [3:0][16:0] boot;
    boot = '0;
    boot[0] = 17'h10000;
    @(negedge clk);
    rst_ = 1'b0;
    pc_out = '0;
    pc_out[0] = pc0;
    pr = '0;
    halt = '0;
    #1;
    check("rst stall", 68'(sn), 68'h0);
    @(posedge clk);
    #1;
    check("rst pc_passed", pp, 68'h0);
    check("rst core_state", 68'(cs), 68'h001);
    check("rst dropped", 68'(dc), 68'h0);
    check("rst stall2", 68'(sn), 68'h0);
    @(negedge clk);
    rst_ = 1'b1;
    pc_out = '0;
    @(posedge clk);
    #1;
    check("boot pulse", pp, boot);
    check("boot core_state", 68'(cs), 68'h001);
    @(posedge clk);
    #1;
    check("boot pulse end", pp, 68'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    v = mk(12'h041, 8'd0, 1'b0);
    v.pc[0] = aw(2'd2, 16'h0100);
    v.pp[2] = 17'h10100;
    tbl.push_back(v);
    v = mk(12'h041, 8'd0, 1'b0);
    tbl.push_back(v);
    v = mk(12'h049, 8'd0, 1'b0);
    v.pc[0] = aw(2'd1, 16'h1234);
    v.pp[1] = 17'h11234;
    tbl.push_back(v);
    v = mk(12'h049, 8'd1, 1'b0);
    v.pr[0] = pz(2'd3);
    tbl.push_back(v);
    v = mk(12'h249, 8'd1, 1'b0);
    v.pc[0] = aw(2'd3, 16'hAAAA);
    v.pc[1] = aw(2'd3, 16'hBBBB);
    v.stall[0] = 3'd6;
    v.pp[3] = 17'h1BBBB;
    tbl.push_back(v);
    v = mk(12'h249, 8'd2, 1'b0);
    v.pc[0] = aw(2'd3, 16'hAAAA);
    tbl.push_back(v);
    v = mk(12'h251, 8'd2, 1'b0);
    v.pr[1] = pz(2'd1);
    tbl.push_back(v);
    v = mk(12'h251, 8'd2, 1'b0);
    v.pr[1] = pz(2'd1);
    v.stall[1] = 3'd6;
    tbl.push_back(v);
    v = mk(12'h249, 8'd2, 1'b0);
    v.pr[1] = pz(2'd1);
    v.pr[0] = rs(2'd1);
    v.stall[1] = 3'd6;
    tbl.push_back(v);
    v = mk(12'h249, 8'd2, 1'b0);
    v.pr[1] = pz(2'd1);
    tbl.push_back(v);
    v = mk(12'h249, 8'd2, 1'b0);
    tbl.push_back(v);
    v = mk(12'h2C9, 8'd2, 1'b0);
    v.halt[2] = 1'b1;
    v.pr[0] = pz(2'd2);
    tbl.push_back(v);
    v = mk(12'h6DB, 8'd2, 1'b1);
    v.halt = 4'b1011;
    tbl.push_back(v);
    v = mk(12'h6DB, 8'd2, 1'b1);
    v.pc[0] = aw(2'd1, 16'h7777);
    tbl.push_back(v);

    do_reset(19'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    do_reset(19'h0);
    for (int i = 0; i < 260; i++) begin
      v = mk(12'h001, (i + 1 > 255) ? 8'd255 : 8'(i + 1), 1'b0);
      v.pc[0] = aw(2'd0, 16'(i));
      run_vec(v, $sformatf("sat%0d", i));
    end

    do_reset(aw(2'd2, 16'h5555));
    v = mk(12'h001, 8'd0, 1'b0);
    run_vec(v, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
